// File: rtl/argmin_stream.sv
`default_nettype none
// ============================================================================
// Module   : argmin_stream
// Brief    : Streaming arg-min over frames of NUM_CAND costs, LANES per beat.
//            Define ARGMIN_SECOND_MIN_EN to add the out_min2 (second-smallest) output.
// Revision : 1.0 - initial release
// ============================================================================
module argmin_stream #(
    parameter int WIDTH      = 6,
    parameter int NUM_CAND   = 64,
    parameter int LANES      = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int TIE_LOW    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [LANES*WIDTH-1:0]  in_costs,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_min,
    output logic [ADDR_WIDTH-1:0]   out_addr
`ifdef ARGMIN_SECOND_MIN_EN
    ,
    output logic [WIDTH-1:0]        out_min2
`endif
);

    localparam int LANE_W    = $clog2(LANES);
    localparam int NUM_BEATS = NUM_CAND / LANES;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

`ifdef ARGMIN_SECOND_MIN_EN
    function automatic logic [WIDTH-1:0] fmin(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction
`endif

    // Level 0 holds the lanes; each higher level halves the node count, left = lower index.
    for (genvar l = 0; l <= LANE_W; l++) begin : g_lvl
        localparam int N = LANES >> l;
        logic [WIDTH-1:0]  val [N];
        logic [LANE_W-1:0] idx [N];
`ifdef ARGMIN_SECOND_MIN_EN
        logic [WIDTH-1:0]  m2  [N];
`endif
        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < N; j++) begin : g_lane
                assign val[j] = in_costs[j*WIDTH +: WIDTH];
                assign idx[j] = LANE_W'(j);
`ifdef ARGMIN_SECOND_MIN_EN
                assign m2[j]  = '1;
`endif
            end
        end else begin : g_node
            for (genvar n = 0; n < N; n++) begin : g_cmp
                logic [WIDTH-1:0] w_lv;
                logic [WIDTH-1:0] w_rv;
                logic             w_take_l;
                assign w_lv     = g_lvl[l-1].val[2*n];
                assign w_rv     = g_lvl[l-1].val[2*n+1];
                assign w_take_l = (TIE_LOW != 0) ? (w_lv <= w_rv) : (w_lv < w_rv);
                assign val[n]   = w_take_l ? w_lv : w_rv;
                assign idx[n]   = w_take_l ? g_lvl[l-1].idx[2*n] : g_lvl[l-1].idx[2*n+1];
`ifdef ARGMIN_SECOND_MIN_EN
                assign m2[n]    = fmin(w_take_l ? w_rv : w_lv,
                                       fmin(g_lvl[l-1].m2[2*n], g_lvl[l-1].m2[2*n+1]));
`endif
            end
        end
    end

    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  s1_valid_q, s1_first_q, s1_last_q;
    logic [WIDTH-1:0]      s1_min_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [WIDTH-1:0]      acc_min_q, acc_min_d;
    logic [ADDR_WIDTH-1:0] acc_addr_q, acc_addr_d;
    logic                  acc_done_q, acc_done_d;
    logic                  out_valid_q;
    logic [WIDTH-1:0]      out_min_q, out_min_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                  w_better;
`ifdef ARGMIN_SECOND_MIN_EN
    logic [WIDTH-1:0]      s1_min2_q, acc_min2_q, acc_min2_d, out_min2_q, out_min2_d;
`endif

    always_comb begin
        beat_d = beat_q;
        if (in_valid) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        end
    end

    assign s1_addr_d = (ADDR_WIDTH'(beat_q) << LANE_W) | ADDR_WIDTH'(g_lvl[LANE_W].idx[0]);
    // Accumulator tie rule is the mirror of the tree rule so earlier beats keep ties under TIE_LOW=1.
    assign w_better  = (TIE_LOW != 0) ? (s1_min_q < acc_min_q) : (s1_min_q <= acc_min_q);

    always_comb begin
        acc_min_d  = acc_min_q;
        acc_addr_d = acc_addr_q;
        acc_done_d = 1'b0;
`ifdef ARGMIN_SECOND_MIN_EN
        acc_min2_d = acc_min2_q;
`endif
        if (s1_valid_q) begin
            acc_done_d = s1_last_q;
            if (s1_first_q || w_better) begin
                acc_min_d  = s1_min_q;
                acc_addr_d = s1_addr_q;
            end
`ifdef ARGMIN_SECOND_MIN_EN
            if (s1_first_q) begin
                acc_min2_d = s1_min2_q;
            end else begin
                acc_min2_d = fmin(w_better ? acc_min_q : s1_min_q, fmin(acc_min2_q, s1_min2_q));
            end
`endif
        end
    end

    always_comb begin
        out_min_d  = out_min_q;
        out_addr_d = out_addr_q;
`ifdef ARGMIN_SECOND_MIN_EN
        out_min2_d = out_min2_q;
`endif
        if (acc_done_q) begin
            out_min_d  = acc_min_q;
            out_addr_d = acc_addr_q;
`ifdef ARGMIN_SECOND_MIN_EN
            out_min2_d = acc_min2_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_min_q    <= '0;
            s1_addr_q   <= '0;
            acc_min_q   <= '0;
            acc_addr_q  <= '0;
            acc_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_min_q   <= '0;
            out_addr_q  <= '0;
`ifdef ARGMIN_SECOND_MIN_EN
            s1_min2_q   <= '1;
            acc_min2_q  <= '0;
            out_min2_q  <= '1;
`endif
        end else if (en) begin
            beat_q      <= beat_d;
            s1_valid_q  <= in_valid;
            if (in_valid) begin
                s1_first_q <= (beat_q == '0);
                s1_last_q  <= (beat_q == LAST_BEAT);
                s1_min_q   <= g_lvl[LANE_W].val[0];
                s1_addr_q  <= s1_addr_d;
`ifdef ARGMIN_SECOND_MIN_EN
                s1_min2_q  <= g_lvl[LANE_W].m2[0];
`endif
            end
            acc_min_q   <= acc_min_d;
            acc_addr_q  <= acc_addr_d;
            acc_done_q  <= acc_done_d;
            out_valid_q <= acc_done_q;
            out_min_q   <= out_min_d;
            out_addr_q  <= out_addr_d;
`ifdef ARGMIN_SECOND_MIN_EN
            acc_min2_q  <= acc_min2_d;
            out_min2_q  <= out_min2_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_min   = out_min_q;
    assign out_addr  = out_addr_q;
`ifdef ARGMIN_SECOND_MIN_EN
    assign out_min2  = out_min2_q;
`endif

endmodule
`default_nettype wire
